// File: rtl/idecode.sv
// RV32I decode stage: captures the fetched instruction and its PC, decodes it into
// a registered packet for execute, and holds the integrated 32x32 register file.
module idecode #(
   parameter bit RF_BYPASS = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_valid,
   input  logic [31:0] f_instr_next,
   input  logic [31:0] f_pc_next,
   input  logic        jump_select,
   input  logic        e_clk_en,
   input  logic        wb_en,
   input  logic [4:0]  wb_rd,
   input  logic [31:0] wb_data,
   output logic        d_clk_en,
   output logic        d_valid,
   output logic [31:0] d_pc,
   output logic [31:0] d_instr,
   output logic [4:0]  d_rs1,
   output logic [4:0]  d_rs2,
   output logic [4:0]  d_rd,
   output logic [31:0] d_rs1_val,
   output logic [31:0] d_rs2_val,
   output logic [31:0] d_imm,
   output logic [3:0]  d_alu_op,
   output logic [3:0]  d_class,
   output logic        d_illegal
);

   localparam logic [3:0] CL_LUI     = 4'd0;
   localparam logic [3:0] CL_AUIPC   = 4'd1;
   localparam logic [3:0] CL_JAL     = 4'd2;
   localparam logic [3:0] CL_JALR    = 4'd3;
   localparam logic [3:0] CL_BRANCH  = 4'd4;
   localparam logic [3:0] CL_LOAD    = 4'd5;
   localparam logic [3:0] CL_STORE   = 4'd6;
   localparam logic [3:0] CL_OP_IMM  = 4'd7;
   localparam logic [3:0] CL_OP      = 4'd8;
   localparam logic [3:0] CL_FENCE   = 4'd9;
   localparam logic [3:0] CL_SYSTEM  = 4'd10;
   localparam logic [3:0] CL_ILLEGAL = 4'd15;

   logic [31:0] rf [32];

   logic [31:0] instr;
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [31:0] i_imm, s_imm, b_imm, u_imm, j_imm;
   logic [3:0]  cls_n;
   logic [4:0]  rs1_n, rs2_n, rd_n;
   logic [31:0] imm_n;
   logic [3:0]  alu_n;
   logic        ill;
   logic [4:0]  rs1_idx, rs2_idx;
   logic [31:0] rs1_rd, rs2_rd;

   assign instr  = f_instr_next;
   assign opcode = instr[6:0];
   assign funct3 = instr[14:12];
   assign funct7 = instr[31:25];

   assign i_imm = {{20{instr[31]}}, instr[31:20]};
   assign s_imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
   assign b_imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
   assign u_imm = {instr[31:12], 12'b0};
   assign j_imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

   always_comb begin
      cls_n = CL_ILLEGAL;
      rs1_n = 5'd0;
      rs2_n = 5'd0;
      rd_n  = 5'd0;
      imm_n = 32'd0;
      alu_n = 4'd0;
      ill   = 1'b0;
      case (opcode)
         7'b0110111: begin cls_n = CL_LUI;   rd_n = instr[11:7]; imm_n = u_imm; end
         7'b0010111: begin cls_n = CL_AUIPC; rd_n = instr[11:7]; imm_n = u_imm; end
         7'b1101111: begin cls_n = CL_JAL;   rd_n = instr[11:7]; imm_n = j_imm; end
         7'b1100111: begin
            cls_n = CL_JALR; rd_n = instr[11:7]; rs1_n = instr[19:15]; imm_n = i_imm;
            ill   = (funct3 != 3'b000);
         end
         7'b1100011: begin
            cls_n = CL_BRANCH; rs1_n = instr[19:15]; rs2_n = instr[24:20]; imm_n = b_imm;
            alu_n = {1'b0, funct3};
            ill   = (funct3 == 3'b010) || (funct3 == 3'b011);
         end
         7'b0000011: begin
            cls_n = CL_LOAD; rd_n = instr[11:7]; rs1_n = instr[19:15]; imm_n = i_imm;
            ill   = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
         end
         7'b0100011: begin
            cls_n = CL_STORE; rs1_n = instr[19:15]; rs2_n = instr[24:20]; imm_n = s_imm;
            ill   = (funct3 > 3'b010);
         end
         7'b0010011: begin
            cls_n = CL_OP_IMM; rd_n = instr[11:7]; rs1_n = instr[19:15]; imm_n = i_imm;
            alu_n = {(funct3 == 3'b101) & instr[30], funct3};
            // Shift immediates reuse the upper bits as funct7; only SRAI may set bit 30.
            if (funct3 == 3'b001)
               ill = (funct7 != 7'b0000000);
            else if (funct3 == 3'b101)
               ill = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
         end
         7'b0110011: begin
            cls_n = CL_OP; rd_n = instr[11:7]; rs1_n = instr[19:15]; rs2_n = instr[24:20];
            alu_n = {instr[30], funct3};
            ill   = !((funct7 == 7'b0000000) ||
                      ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
         end
         7'b0001111: begin cls_n = CL_FENCE;  rd_n = instr[11:7]; rs1_n = instr[19:15]; end
         7'b1110011: begin cls_n = CL_SYSTEM; rd_n = instr[11:7]; rs1_n = instr[19:15]; end
         default:    ill = 1'b1;
      endcase
      if (instr[1:0] != 2'b11)
         ill = 1'b1;
      if (ill) begin
         cls_n = CL_ILLEGAL;
         rs1_n = 5'd0;
         rs2_n = 5'd0;
         rd_n  = 5'd0;
         imm_n = 32'd0;
         alu_n = 4'd0;
      end
   end

   // Reads use the raw source fields so operand fetch never waits on the decode above.
   assign rs1_idx = instr[19:15];
   assign rs2_idx = instr[24:20];

   always_comb begin
      rs1_rd = rf[rs1_idx];
      rs2_rd = rf[rs2_idx];
      if (RF_BYPASS && wb_en && (wb_rd == rs1_idx))
         rs1_rd = wb_data;
      if (RF_BYPASS && wb_en && (wb_rd == rs2_idx))
         rs2_rd = wb_data;
      if (rs1_idx == 5'd0)
         rs1_rd = 32'd0;
      if (rs2_idx == 5'd0)
         rs2_rd = 32'd0;
   end

   always_ff @(posedge clk) begin
      if (wb_en && (wb_rd != 5'd0))
         rf[wb_rd] <= wb_data;
   end

   // Handshake: the packet is offered while d_valid is high and is taken on any edge
   // where e_clk_en is high; an empty stage always loads, and a redirect drops the packet.
   assign d_clk_en = jump_select | e_clk_en | !d_valid;

   always_ff @(posedge clk) begin
      if (rst) begin
         d_valid   <= 1'b0;
         d_pc      <= 32'd0;
         d_instr   <= 32'h0000_0013;
         d_rs1     <= 5'd0;
         d_rs2     <= 5'd0;
         d_rd      <= 5'd0;
         d_rs1_val <= 32'd0;
         d_rs2_val <= 32'd0;
         d_imm     <= 32'd0;
         d_alu_op  <= 4'd0;
         d_class   <= CL_OP_IMM;
      end else if (jump_select) begin
         d_valid <= 1'b0;
      end else if (d_clk_en) begin
         d_valid   <= i_valid;
         d_pc      <= f_pc_next;
         d_instr   <= f_instr_next;
         d_rs1     <= rs1_n;
         d_rs2     <= rs2_n;
         d_rd      <= rd_n;
         d_rs1_val <= rs1_rd;
         d_rs2_val <= rs2_rd;
         d_imm     <= imm_n;
         d_alu_op  <= alu_n;
         d_class   <= cls_n;
      end
   end

   assign d_illegal = (d_class == CL_ILLEGAL);

endmodule

// File: tb/tb_idecode.sv
// Directed bench for idecode: reset, bypass, stall, flush, decode vector table,
// x0 protection and register-file retention across reset.
module tb_idecode;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_valid;
   logic [31:0] f_instr_next;
   logic [31:0] f_pc_next;
   logic        jump_select;
   logic        e_clk_en;
   logic        wb_en;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        d_clk_en;
   logic        d_valid;
   logic [31:0] d_pc;
   logic [31:0] d_instr;
   logic [4:0]  d_rs1, d_rs2, d_rd;
   logic [31:0] d_rs1_val, d_rs2_val;
   logic [31:0] d_imm;
   logic [3:0]  d_alu_op;
   logic [3:0]  d_class;
   logic        d_illegal;

   int n_checks = 0;
   int n_fail   = 0;
   logic [31:0] exp_q[$];

   typedef struct {
      logic [31:0] instr;
      logic [3:0]  cls;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [31:0] imm;
      logic [3:0]  alu;
      logic        ill;
   } vec_t;

   vec_t vecs[$];

   idecode #(.RF_BYPASS(1'b1)) dut (
      .clk(clk), .rst(rst), .i_valid(i_valid), .f_instr_next(f_instr_next),
      .f_pc_next(f_pc_next), .jump_select(jump_select), .e_clk_en(e_clk_en),
      .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .d_clk_en(d_clk_en),
      .d_valid(d_valid), .d_pc(d_pc), .d_instr(d_instr), .d_rs1(d_rs1),
      .d_rs2(d_rs2), .d_rd(d_rd), .d_rs1_val(d_rs1_val), .d_rs2_val(d_rs2_val),
      .d_imm(d_imm), .d_alu_op(d_alu_op), .d_class(d_class), .d_illegal(d_illegal)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [31:0] instr, input logic [31:0] pc, input logic iv,
                        input logic js, input logic ee);
      f_instr_next = instr;
      f_pc_next    = pc;
      i_valid      = iv;
      jump_select  = js;
      e_clk_en     = ee;
   endtask

   task automatic wb(input logic en, input logic [4:0] rd, input logic [31:0] data);
      wb_en   = en;
      wb_rd   = rd;
      wb_data = data;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic add_vec(input logic [31:0] instr, input logic [3:0] cls, input logic [4:0] rd,
                          input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm,
                          input logic [3:0] alu, input logic ill);
      vec_t v;
      v.instr = instr; v.cls = cls; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
      v.imm = imm; v.alu = alu; v.ill = ill;
      vecs.push_back(v);
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_valid"}, {31'd0, d_valid}, 32'd0);
      chk({tag, "_pc"}, d_pc, 32'd0);
      chk({tag, "_instr"}, d_instr, 32'h0000_0013);
      chk({tag, "_class"}, {28'd0, d_class}, 32'd7);
      chk({tag, "_alu"}, {28'd0, d_alu_op}, 32'd0);
      chk({tag, "_imm"}, d_imm, 32'd0);
      chk({tag, "_rd"}, {27'd0, d_rd}, 32'd0);
      chk({tag, "_rs1v"}, d_rs1_val, 32'd0);
      chk({tag, "_ill"}, {31'd0, d_illegal}, 32'd0);
      chk({tag, "_clk_en"}, {31'd0, d_clk_en}, 32'd1);
   endtask

   initial begin
      rst = 1'b1;
      drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      wb(1'b0, 5'd0, 32'd0);

      // Reset for two cycles.
      for (int i = 0; i < 2; i++) begin
         tick();
         chk_reset_state("reset");
      end

      // First fetch: addi x1,x0,5 while x1 is written with a known value.
      rst = 1'b0;
      drive(32'h0050_0093, 32'h0, 1'b1, 1'b0, 1'b1);
      wb(1'b1, 5'd1, 32'h1111_1111);
      tick();
      chk("first_valid", {31'd0, d_valid}, 32'd1);
      chk("first_class", {28'd0, d_class}, 32'd7);
      chk("first_rd", {27'd0, d_rd}, 32'd1);
      chk("first_imm", d_imm, 32'd5);
      chk("first_rs1v", d_rs1_val, 32'd0);

      // Bypass: add x3,x1,x2 while x2 is being written.
      drive(32'h0020_81B3, 32'h4, 1'b1, 1'b0, 1'b1);
      wb(1'b1, 5'd2, 32'hDEAD_BEEF);
      tick();
      chk("byp_rs2v", d_rs2_val, 32'hDEAD_BEEF);
      chk("byp_rs1v", d_rs1_val, 32'h1111_1111);
      chk("byp_alu", {28'd0, d_alu_op}, 32'd0);
      chk("byp_class", {28'd0, d_class}, 32'd8);
      chk("byp_regs", {17'd0, d_rd, d_rs1, d_rs2}, {17'd0, 5'd3, 5'd1, 5'd2});

      // Stall three cycles while the input changes and x1 is rewritten under the held packet.
      for (int k = 0; k < 3; k++) begin
         drive(32'h0000_0033 + (k << 7), 32'h40 + k * 4, 1'b1, 1'b0, 1'b0);
         wb(1'b1, 5'd1, 32'hA000_0000 + k);
         #1;
         chk("stall_clk_en", {31'd0, d_clk_en}, 32'd0);
         tick();
         chk("stall_pc", d_pc, 32'h4);
         chk("stall_instr", d_instr, 32'h0020_81B3);
         chk("stall_rs1v", d_rs1_val, 32'h1111_1111);
         chk("stall_valid", {31'd0, d_valid}, 32'd1);
      end

      // Release: sra x3,x1,x2 loads one edge later and sees the stored x1/x2.
      wb(1'b0, 5'd0, 32'd0);
      drive(32'h4020_D1B3, 32'h8, 1'b1, 1'b0, 1'b1);
      #1;
      chk("release_clk_en", {31'd0, d_clk_en}, 32'd1);
      tick();
      chk("release_pc", d_pc, 32'h8);
      chk("release_alu", {28'd0, d_alu_op}, 32'hD);
      chk("release_rs1v", d_rs1_val, 32'hA000_0002);
      chk("release_rs2v", d_rs2_val, 32'hDEAD_BEEF);

      // Flush wins over advance and i_valid.
      drive(32'h0050_0093, 32'hC, 1'b1, 1'b1, 1'b1);
      tick();
      chk("flush_valid", {31'd0, d_valid}, 32'd0);
      chk("flush_clk_en", {31'd0, d_clk_en}, 32'd1);

      // Decode vector table.
      add_vec(32'hFE00_0EE3, 4'd4,  5'd0, 5'd0, 5'd0, 32'hFFFF_FFFC, 4'h0, 1'b0); // beq -4
      add_vec(32'h8000_006F, 4'd2,  5'd0, 5'd0, 5'd0, 32'hFFF0_0000, 4'h0, 1'b0); // jal
      add_vec(32'h4020_D1B3, 4'd8,  5'd3, 5'd1, 5'd2, 32'h0,         4'hD, 1'b0); // sra
      add_vec(32'h4020_81B3, 4'd8,  5'd3, 5'd1, 5'd2, 32'h0,         4'h8, 1'b0); // sub
      add_vec(32'h0000_0000, 4'd15, 5'd0, 5'd0, 5'd0, 32'h0,         4'h0, 1'b1);
      add_vec(32'h0200_80B3, 4'd15, 5'd0, 5'd0, 5'd0, 32'h0,         4'h0, 1'b1); // funct7 1
      add_vec(32'h4020_91B3, 4'd15, 5'd0, 5'd0, 5'd0, 32'h0,         4'h0, 1'b1); // alt sll
      add_vec(32'h1234_52B7, 4'd0,  5'd5, 5'd0, 5'd0, 32'h1234_5000, 4'h0, 1'b0); // lui
      add_vec(32'h0000_1397, 4'd1,  5'd7, 5'd0, 5'd0, 32'h0000_1000, 4'h0, 1'b0); // auipc
      add_vec(32'h0020_A423, 4'd6,  5'd0, 5'd1, 5'd2, 32'h8,         4'h0, 1'b0); // sw
      add_vec(32'h0020_B023, 4'd15, 5'd0, 5'd0, 5'd0, 32'h0,         4'h0, 1'b1); // store f3=3
      add_vec(32'hFFF0_A203, 4'd5,  5'd4, 5'd1, 5'd0, 32'hFFFF_FFFF, 4'h0, 1'b0); // lw -1
      add_vec(32'h0000_B203, 4'd15, 5'd0, 5'd0, 5'd0, 32'h0,         4'h0, 1'b1); // load f3=3
      add_vec(32'h4030_D313, 4'd7,  5'd6, 5'd1, 5'd0, 32'h0000_0403, 4'hD, 1'b0); // srai
      add_vec(32'h4030_9313, 4'd15, 5'd0, 5'd0, 5'd0, 32'h0,         4'h0, 1'b1); // bad slli
      add_vec(32'h4000_8093, 4'd7,  5'd1, 5'd1, 5'd0, 32'h0000_0400, 4'h0, 1'b0); // addi 0x400
      add_vec(32'h0020_9463, 4'd4,  5'd0, 5'd1, 5'd2, 32'h8,         4'h1, 1'b0); // bne +8
      add_vec(32'h0000_2063, 4'd15, 5'd0, 5'd0, 5'd0, 32'h0,         4'h0, 1'b1); // branch f3=2
      add_vec(32'h0041_00E7, 4'd3,  5'd1, 5'd2, 5'd0, 32'h4,         4'h0, 1'b0); // jalr
      add_vec(32'h0041_10E7, 4'd15, 5'd0, 5'd0, 5'd0, 32'h0,         4'h0, 1'b1); // jalr f3=1
      add_vec(32'h0000_0073, 4'd10, 5'd0, 5'd0, 5'd0, 32'h0,         4'h0, 1'b0); // ecall
      add_vec(32'h0FF0_000F, 4'd9,  5'd0, 5'd0, 5'd0, 32'h0,         4'h0, 1'b0); // fence
      add_vec(32'h0050_0091, 4'd15, 5'd0, 5'd0, 5'd0, 32'h0,         4'h0, 1'b1); // bits[1:0]

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].instr, 32'h100 + i * 4, 1'b1, 1'b0, 1'b1);
         exp_q.push_back(vecs[i].instr);
         tick();
         chk($sformatf("vec%0d_instr", i), d_instr, exp_q.pop_front());
         chk($sformatf("vec%0d_valid", i), {31'd0, d_valid}, 32'd1);
         chk($sformatf("vec%0d_pc", i), d_pc, 32'h100 + i * 4);
         chk($sformatf("vec%0d_class", i), {28'd0, d_class}, {28'd0, vecs[i].cls});
         chk($sformatf("vec%0d_regs", i), {17'd0, d_rd, d_rs1, d_rs2},
             {17'd0, vecs[i].rd, vecs[i].rs1, vecs[i].rs2});
         chk($sformatf("vec%0d_imm", i), d_imm, vecs[i].imm);
         chk($sformatf("vec%0d_alu", i), {28'd0, d_alu_op}, {28'd0, vecs[i].alu});
         chk($sformatf("vec%0d_ill", i), {31'd0, d_illegal}, {31'd0, vecs[i].ill});
      end

      // x0 write is ignored, both as bypass and as storage.
      drive(32'h0000_01B3, 32'h200, 1'b1, 1'b0, 1'b1);
      wb(1'b1, 5'd0, 32'hFFFF_FFFF);
      tick();
      chk("x0_byp_rs1v", d_rs1_val, 32'd0);
      chk("x0_byp_rs2v", d_rs2_val, 32'd0);
      wb(1'b0, 5'd0, 32'd0);
      drive(32'h0000_01B3, 32'h204, 1'b1, 1'b0, 1'b1);
      tick();
      chk("x0_store_rs1v", d_rs1_val, 32'd0);
      chk("x0_store_rs2v", d_rs2_val, 32'd0);

      // Reset mid-operation drops the packet but keeps register contents.
      rst = 1'b1;
      drive(32'h0020_81B3, 32'h208, 1'b1, 1'b0, 1'b1);
      tick();
      chk_reset_state("midrst");
      rst = 1'b0;
      tick();
      chk("post_rst_valid", {31'd0, d_valid}, 32'd1);
      chk("post_rst_rs1v", d_rs1_val, 32'hA000_0002);
      chk("post_rst_rs2v", d_rs2_val, 32'hDEAD_BEEF);

      // Empty stage loads even without e_clk_en.
      drive(32'h0050_0093, 32'h20C, 1'b0, 1'b1, 1'b0);
      tick();
      drive(32'h0050_0093, 32'h210, 1'b1, 1'b0, 1'b0);
      #1;
      chk("empty_clk_en", {31'd0, d_clk_en}, 32'd1);
      tick();
      chk("empty_load_valid", {31'd0, d_valid}, 32'd1);
      chk("empty_load_pc", d_pc, 32'h210);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
